// File: rtl/rr_req_buffer_if.sv
// Handshake bundle between N clients, the round-robin arbiter and the rr_req_buffer output port.
// The buffer connects through the slave modport; the driving side (clients/arbiter model) uses master.
interface rr_req_buffer_if #(
   parameter int N  = 4,
   parameter int DW = 8
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]    in_valid;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_ready;
   logic [N-1:0]    req;
   logic [N-1:0]    grant;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [IW-1:0]   out_id;
   logic            grant_err;

   modport master (
      output in_valid, in_data, grant,
      input  in_ready, req, out_valid, out_data, out_id, grant_err
   );

   modport slave (
      input  in_valid, in_data, grant,
      output in_ready, req, out_valid, out_data, out_id, grant_err
   );
endinterface

// File: rtl/rr_req_buffer.sv
// Per-client FIFOs feeding a round-robin arbiter: req from occupancy, grant pops one head word per cycle.
// Optional grant protocol checker enabled by defining RR_REQ_BUF_GRANT_CHK_EN.
module rr_req_buffer #(
   parameter int N     = 4,
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input logic            clk,
   input logic            reset,
   rr_req_buffer_if.slave bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DW-1:0] mem_q    [N][DEPTH];
   logic [DW-1:0] mem_d    [N][DEPTH];
   logic [PW-1:0] rd_ptr_q [N];
   logic [PW-1:0] rd_ptr_d [N];
   logic [PW-1:0] wr_ptr_q [N];
   logic [PW-1:0] wr_ptr_d [N];
   logic [CW-1:0] cnt_q    [N];
   logic [CW-1:0] cnt_d    [N];
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [IW-1:0] out_id_q, out_id_d;

   logic [N-1:0]  in_ready_s;
   logic [N-1:0]  req_s;
   logic [N-1:0]  push_s;
   logic [N-1:0]  pop_s;
   logic [IW-1:0] pop_idx_s;
   logic          one_hot_s;
   logic          pop_ok_s;

   // Occupancy flags; a full FIFO refuses pushes even while it is being popped
   always_comb begin
      in_ready_s = '0;
      req_s      = '0;
      for (int i = 0; i < N; i++) begin
         in_ready_s[i] = (cnt_q[i] != FULL) && !reset;
         req_s[i]      = (cnt_q[i] != '0);
      end
   end

   // Grant decode: only a one-hot grant to a non-empty FIFO pops
   always_comb begin
      pop_idx_s = '0;
      for (int i = 0; i < N; i++) begin
         pop_idx_s = pop_idx_s | (bus.grant[i] ? IW'(i) : '0);
      end
      one_hot_s = (bus.grant != '0) && ((bus.grant & (bus.grant - N'(1))) == '0);
      pop_ok_s  = one_hot_s && req_s[pop_idx_s];
   end

   // FIFO next state and output register next state
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      push_s   = '0;
      pop_s    = '0;
      for (int i = 0; i < N; i++) begin
         push_s[i] = bus.in_valid[i] && in_ready_s[i];
         pop_s[i]  = pop_ok_s && (pop_idx_s == IW'(i));
         if (push_s[i]) begin
            mem_d[i][wr_ptr_q[i]] = bus.in_data[i*DW +: DW];
            wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
         end else begin
            wr_ptr_d[i] = wr_ptr_q[i];
         end
         if (pop_s[i]) begin
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
         end else begin
            rd_ptr_d[i] = rd_ptr_q[i];
         end
         case ({push_s[i], pop_s[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
      out_valid_d = pop_ok_s;
      if (pop_ok_s) begin
         out_data_d = mem_q[pop_idx_s][rd_ptr_q[pop_idx_s]];
         out_id_d   = pop_idx_s;
      end else begin
         out_data_d = out_data_q;
         out_id_d   = out_id_q;
      end
   end

   // State registers; reset discards all buffered words
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
            for (int j = 0; j < DEPTH; j++) begin
               mem_q[i][j] <= '0;
            end
         end
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else begin
         mem_q       <= mem_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
      end
   end

`ifdef RR_REQ_BUF_GRANT_CHK_EN
   logic grant_err_q, grant_err_d;

   // Any non-zero grant that does not pop is multi-hot or hits an empty FIFO
   always_comb begin
      grant_err_d = grant_err_q | ((bus.grant != '0) && !pop_ok_s);
   end

   // Sticky error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_err_q <= 1'b0;
      end else begin
         grant_err_q <= grant_err_d;
      end
   end

   assign bus.grant_err = grant_err_q;
`else
   assign bus.grant_err = 1'b0;
`endif

   assign bus.in_ready  = in_ready_s;
   assign bus.req       = req_s;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
endmodule
